// File: rtl/arith_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : arith_enc_pkg
//  Description : Shared constants for the arithmetic-encoder pipeline control.
//  Revision    : 1.0 - initial release
// ============================================================================
package arith_enc_pkg;

    localparam int c_DEF_NUM_STAGES = 3;
    localparam int c_DEF_ISSUE_GAP  = 1;
    localparam int c_DEF_CNT_W      = 16;

    typedef logic [1:0] pipe_state_t;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/arith_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : arith_pipe_ctrl_if
//  Description : Handshake, flush and stage-control bundle of the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface arith_pipe_ctrl_if
    import arith_enc_pkg::*;
#(
    parameter int NUM_STAGES = c_DEF_NUM_STAGES,
    parameter int CNT_W      = c_DEF_CNT_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic                  out_ready;
    logic                  out_valid;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_valid;
    logic                  mux_reset;
    logic                  flush_done;
    logic [CNT_W-1:0]      sym_count;

    modport master (
        output in_valid, flush, out_ready,
        input  in_ready, out_valid, stage_en, stage_valid,
        input  mux_reset, flush_done, sym_count
    );

    modport slave (
        input  in_valid, flush, out_ready,
        output in_ready, out_valid, stage_en, stage_valid,
        output mux_reset, flush_done, sym_count
    );
endinterface
`default_nettype wire

// File: rtl/arith_pipe_valid_sr.sv
`default_nettype none
// ============================================================================
//  Module      : arith_pipe_valid_sr
//  Description : Per-stage valid shift register that holds while stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_pipe_valid_sr #(
    parameter int NUM_STAGES = 3
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_advance,
    input  wire logic                  i_shift_in,
    output logic      [NUM_STAGES-1:0] o_valid
);
    logic [NUM_STAGES-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_advance) begin
            r_valid <= {r_valid[NUM_STAGES-2:0], i_shift_in};
        end
    end

    assign o_valid = r_valid;
endmodule
`default_nettype wire

// File: rtl/arith_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arith_pipe_ctrl
//  Description : Stage enables, valid tracking, issue gap and flush/drain FSM
//                for the arithmetic-encoder datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_pipe_ctrl
    import arith_enc_pkg::*;
#(
    parameter int NUM_STAGES = c_DEF_NUM_STAGES,
    parameter int ISSUE_GAP  = c_DEF_ISSUE_GAP,
    parameter int CNT_W      = c_DEF_CNT_W
) (
    input  wire logic        clk,
    input  wire logic        reset_ctrl,
    arith_pipe_ctrl_if.slave bus
);
    localparam int               c_GAP_W    = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(ISSUE_GAP);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);

    pipe_state_t           r_state;
    pipe_state_t           w_state_nxt;
    logic [c_GAP_W-1:0]    r_gap_cnt;
    logic [CNT_W-1:0]      r_sym_count;
    logic                  r_first_sym;
    logic [NUM_STAGES-1:0] w_valid;

    logic w_advance;
    logic w_issue_state;
    logic w_in_ready;
    logic w_accept;
    logic w_drain_done;
    logic w_flush_done;

    // One stalled output freezes every stage.
    assign w_advance     = !(w_valid[NUM_STAGES-1] && !bus.out_ready);
    assign w_issue_state = (r_state == c_ST_IDLE) || (r_state == c_ST_RUN);
    assign w_in_ready    = w_advance && (r_gap_cnt == '0) && w_issue_state && !reset_ctrl;
    assign w_accept      = bus.in_valid && w_in_ready;
    // Pipe is empty after this edge: nothing enters during DRAIN and the last stage leaves.
    assign w_drain_done  = w_advance && (w_valid[NUM_STAGES-2:0] == '0);
    assign w_flush_done  = (r_state == c_ST_DONE) && !reset_ctrl;

    arith_pipe_valid_sr #(
        .NUM_STAGES (NUM_STAGES)
    ) u_valid_sr (
        .clk        (clk),
        .rst        (reset_ctrl),
        .i_advance  (w_advance),
        .i_shift_in (w_accept),
        .o_valid    (w_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.flush) begin
                    w_state_nxt = c_ST_DRAIN;
                end else if (w_accept) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (bus.flush) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_ctrl) begin
            r_state     <= c_ST_IDLE;
            r_gap_cnt   <= '0;
            r_sym_count <= '0;
            r_first_sym <= 1'b1;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_gap_cnt <= c_GAP_LOAD;
            end else if (w_advance && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
            end

            if (w_flush_done) begin
                r_sym_count <= '0;
            end else if (w_accept && (r_sym_count != '1)) begin
                r_sym_count <= r_sym_count + 1'b1;
            end

            if (w_flush_done) begin
                r_first_sym <= 1'b1;
            end else if (w_accept) begin
                r_first_sym <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_valid[NUM_STAGES-1];
    assign bus.stage_en    = reset_ctrl ? '0 : {NUM_STAGES{w_advance}};
    assign bus.stage_valid = w_valid;
    assign bus.mux_reset   = w_accept && r_first_sym;
    assign bus.flush_done  = w_flush_done;
    assign bus.sym_count   = r_sym_count;
endmodule
`default_nettype wire

// File: tb/tb_arith_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arith_pipe_ctrl
//  Description : Directed scoreboard bench for two controller instances
//                (issue gap 1 and issue gap 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_pipe_ctrl;
    localparam int N  = 3;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_ctrl;
    logic sel;
    logic iv, fl, ordy;

    arith_pipe_ctrl_if #(.NUM_STAGES(N), .CNT_W(CW)) bus_g1();
    arith_pipe_ctrl_if #(.NUM_STAGES(N), .CNT_W(CW)) bus_g0();

    arith_pipe_ctrl #(.NUM_STAGES(N), .ISSUE_GAP(1), .CNT_W(CW)) u_dut_g1 (
        .clk        (clk),
        .reset_ctrl (reset_ctrl),
        .bus        (bus_g1.slave)
    );

    arith_pipe_ctrl #(.NUM_STAGES(N), .ISSUE_GAP(0), .CNT_W(CW)) u_dut_g0 (
        .clk        (clk),
        .reset_ctrl (reset_ctrl),
        .bus        (bus_g0.slave)
    );

    assign bus_g1.in_valid  = !sel && iv;
    assign bus_g1.flush     = !sel && fl;
    assign bus_g1.out_ready = sel ? 1'b1 : ordy;
    assign bus_g0.in_valid  = sel && iv;
    assign bus_g0.flush     = sel && fl;
    assign bus_g0.out_ready = sel ? ordy : 1'b1;

    logic          w_in_ready, w_out_valid, w_out_ready, w_mux_reset, w_flush_done;
    logic [N-1:0]  w_stage_en, w_stage_valid;
    logic [CW-1:0] w_sym_count;

    assign w_in_ready    = sel ? bus_g0.in_ready    : bus_g1.in_ready;
    assign w_out_valid   = sel ? bus_g0.out_valid   : bus_g1.out_valid;
    assign w_out_ready   = sel ? bus_g0.out_ready   : bus_g1.out_ready;
    assign w_mux_reset   = sel ? bus_g0.mux_reset   : bus_g1.mux_reset;
    assign w_flush_done  = sel ? bus_g0.flush_done  : bus_g1.flush_done;
    assign w_stage_en    = sel ? bus_g0.stage_en    : bus_g1.stage_en;
    assign w_stage_valid = sel ? bus_g0.stage_valid : bus_g1.stage_valid;
    assign w_sym_count   = sel ? bus_g0.sym_count   : bus_g1.sym_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each completed output must land on the cycle predicted when it was issued.
    always @(negedge clk) begin
        if (w_out_valid === 1'b1 && w_out_ready === 1'b1) begin
            if (q.size() == 0) begin
                chk("sb_underflow", q.size(), 1);
            end else begin
                chk("emerge_cycle", cyc, q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic f, input logic r,
                         input logic exp_rdy, input logic exp_mux, input int extra);
        iv   = v;
        fl   = f;
        ordy = r;
        @(negedge clk);
        chk("in_ready", w_in_ready, exp_rdy);
        chk("mux_reset", w_mux_reset, exp_mux);
        if (v && exp_rdy) q.push_back(cyc + N + extra);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        iv   = 1'b0;
        fl   = 1'b0;
        ordy = 1'b1;
        repeat (n) nxt();
    endtask

    initial begin
        sel        = 1'b0;
        iv         = 1'b0;
        fl         = 1'b0;
        ordy       = 1'b1;
        reset_ctrl = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", w_in_ready, 0);
        chk("rst_stage_en", w_stage_en, 0);
        chk("rst_stage_valid", w_stage_valid, 0);
        chk("rst_out_valid", w_out_valid, 0);
        chk("rst_flush_done", w_flush_done, 0);
        chk("rst_sym_count", w_sym_count, 0);
        nxt();
        reset_ctrl = 1'b0;

        // Gap 1, back-to-back requests: ready 1,0,1,0,1
        drive(1, 0, 1, 1, 1, 0); nxt();
        drive(1, 0, 1, 0, 0, 0); nxt();
        drive(1, 0, 1, 1, 0, 0);
        chk("stage_en_run", w_stage_en, 3'b111);
        nxt();
        drive(1, 0, 1, 0, 0, 0); nxt();
        drive(1, 0, 1, 1, 0, 0); nxt();
        idle(6);
        drive(0, 0, 1, 1, 0, 0);
        chk("sym_count_3", w_sym_count, 3);
        nxt();

        // Gap 0, full rate for 8 cycles
        sel = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1, 1, (i == 0), 0);
            nxt();
        end
        idle(4);
        drive(0, 0, 1, 1, 0, 0);
        chk("sym_count_8", w_sym_count, 8);
        nxt();

        // Gap 1, 4-cycle downstream stall with two symbols in flight
        sel = 1'b0;
        drive(1, 0, 1, 1, 0, 4); nxt();
        drive(1, 0, 1, 0, 0, 0); nxt();
        drive(1, 0, 1, 1, 0, 4); nxt();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            chk("stall_stage_en", w_stage_en, 0);
            chk("stall_valid", w_stage_valid, 3'b101);
            chk("stall_out_valid", w_out_valid, 1);
            nxt();
        end
        drive(1, 0, 1, 0, 0, 0);
        chk("resume_valid", w_stage_valid, 3'b101);
        nxt();
        drive(1, 0, 1, 1, 0, 0); nxt();
        idle(5);

        // Flush together with an accept
        drive(1, 1, 1, 1, 0, 0); nxt();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            chk("drain_flush_done", w_flush_done, 0);
            nxt();
        end
        drive(0, 0, 1, 0, 0, 0);
        chk("flush_done_pulse", w_flush_done, 1);
        chk("sym_count_pre_clear", w_sym_count, 7);
        nxt();
        drive(1, 0, 1, 1, 1, 0);
        chk("flush_done_single", w_flush_done, 0);
        chk("sym_count_cleared", w_sym_count, 0);
        nxt();
        idle(5);

        // Reset with two symbols in flight (gap 0 instance)
        sel = 1'b1;
        drive(1, 0, 1, 1, 0, 0); nxt();
        drive(1, 0, 1, 1, 0, 0); nxt();
        reset_ctrl = 1'b1;
        drive(1, 0, 1, 0, 0, 0);
        chk("rst_mid_stage_en", w_stage_en, 0);
        q.delete();
        nxt();
        drive(1, 0, 1, 0, 0, 0);
        chk("rst_mid_valid", w_stage_valid, 0);
        chk("rst_mid_out_valid", w_out_valid, 0);
        chk("rst_mid_sym_count", w_sym_count, 0);
        chk("rst_mid_flush_done", w_flush_done, 0);
        chk("rst_mid_stage_en2", w_stage_en, 0);
        nxt();
        reset_ctrl = 1'b0;
        idle(5);

        // Flush in IDLE with an empty pipe (gap 1 instance)
        sel = 1'b0;
        drive(0, 1, 1, 1, 0, 0);
        chk("idle_flush_done0", w_flush_done, 0);
        nxt();
        drive(0, 0, 1, 0, 0, 0);
        chk("idle_flush_done1", w_flush_done, 0);
        chk("idle_flush_out1", w_out_valid, 0);
        nxt();
        drive(0, 0, 1, 0, 0, 0);
        chk("idle_flush_done2", w_flush_done, 1);
        chk("idle_flush_out2", w_out_valid, 0);
        nxt();
        drive(0, 0, 1, 1, 0, 0);
        chk("idle_flush_done3", w_flush_done, 0);
        nxt();
        idle(2);

        chk("sb_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
